burst_scheduler: RTL and testbench

//  Sequences the modulator datapath through a programmable table of bursts. Each entry gives mod_type, amplitude,

---
 rtl/burst_sched_pkg.sv | 27 ++
 rtl/burst_scheduler_if.sv | 42 ++++
 rtl/burst_sched_table.sv | 23 ++
 rtl/burst_scheduler.sv | 169 ++++++++++++++++
 tb/tb_burst_scheduler.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/burst_sched_pkg.sv
// Shared types and reset constants for the burst scheduler.
package burst_sched_pkg;

  localparam int MOD_BW = 3;
  localparam int AMP_BW = 32;
  localparam int SPS_BW = 32;
  localparam int LEN_BW = 24;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN
  } state_e;

  typedef struct packed {
    logic [MOD_BW-1:0] mod;
    logic [AMP_BW-1:0] amp;
    logic [SPS_BW-1:0] sps;
    logic [LEN_BW-1:0] len;
  } entry_t;

  localparam logic [MOD_BW-1:0] MOD_RST = '0;
  localparam logic [AMP_BW-1:0] AMP_RST = AMP_BW'(1024);
  localparam logic [SPS_BW-1:0] SPS_RST = SPS_BW'(4);

endpackage

// File: rtl/burst_scheduler_if.sv
// Control, table-write, IQ-monitor and modulator-config bundle of the burst scheduler.
interface burst_scheduler_if
  import burst_sched_pkg::*;
#(
  parameter int DEPTH = 16
) ();
  localparam int ADDR_BW = $clog2(DEPTH);

  logic                tbl_wr_en;
  logic [ADDR_BW-1:0]  tbl_wr_addr;
  logic [MOD_BW-1:0]   tbl_wr_mod;
  logic [AMP_BW-1:0]   tbl_wr_amp;
  logic [SPS_BW-1:0]   tbl_wr_sps;
  logic [LEN_BW-1:0]   tbl_wr_len;
  logic [ADDR_BW:0]    num_entries;
  logic                ctrl_go;
  logic                ctrl_stop;
  logic                ctrl_loop;
  logic                iq_tvalid;
  logic                iq_tready;
  logic [MOD_BW-1:0]   mod_type;
  logic [AMP_BW-1:0]   amplitude;
  logic [SPS_BW-1:0]   samples_per_symbol;
  logic                start;
  logic                iq_gate;
  logic                busy;
  logic [ADDR_BW-1:0]  cur_entry;
  logic                burst_done;

  modport master (
    output tbl_wr_en, tbl_wr_addr, tbl_wr_mod, tbl_wr_amp, tbl_wr_sps, tbl_wr_len,
    output num_entries, ctrl_go, ctrl_stop, ctrl_loop, iq_tvalid, iq_tready,
    input  mod_type, amplitude, samples_per_symbol, start, iq_gate, busy, cur_entry, burst_done
  );

  modport slave (
    input  tbl_wr_en, tbl_wr_addr, tbl_wr_mod, tbl_wr_amp, tbl_wr_sps, tbl_wr_len,
    input  num_entries, ctrl_go, ctrl_stop, ctrl_loop, iq_tvalid, iq_tready,
    output mod_type, amplitude, samples_per_symbol, start, iq_gate, busy, cur_entry, burst_done
  );

endinterface

// File: rtl/burst_sched_table.sv
// Burst table: simple dual-port RAM with registered read; a same-address write returns old data.
module burst_sched_table
  import burst_sched_pkg::*;
#(
  parameter  int DEPTH   = 16,
  localparam int ADDR_BW = $clog2(DEPTH)
) (
  input  logic               ap_clk,
  input  logic               wr_en_i,
  input  logic [ADDR_BW-1:0] wr_addr_i,
  input  entry_t             wr_data_i,
  input  logic [ADDR_BW-1:0] rd_addr_i,
  output entry_t             rd_data_o
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge ap_clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/burst_scheduler.sv
// Plays a table of modulator bursts, gating the settle samples after each config load.
// Looping playback on ctrl_loop is compiled in only when BURST_SCHED_LOOP_EN is defined.
module burst_scheduler
  import burst_sched_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SETTLE_SAMP = 64
) (
  input logic              ap_clk,
  input logic              ap_rst,
  burst_scheduler_if.slave bus
);

  localparam int ADDR_BW = $clog2(DEPTH);
  localparam int SET_W   = (SETTLE_SAMP > 1) ? $clog2(SETTLE_SAMP) : 1;
  localparam logic [SET_W-1:0]   SET_LAST = SET_W'((SETTLE_SAMP > 0) ? SETTLE_SAMP - 1 : 0);
  localparam logic [SET_W-1:0]   SET_ONE  = SET_W'(1);
  localparam logic [LEN_BW-1:0]  LEN_ONE  = LEN_BW'(1);
  localparam logic [ADDR_BW-1:0] ENT_ONE  = ADDR_BW'(1);
  localparam logic [ADDR_BW:0]   NENT_ONE = (ADDR_BW + 1)'(1);

  state_e             state_q, state_d;
  logic [ADDR_BW-1:0] entry_q, entry_d;
  logic [ADDR_BW:0]   nent_q, nent_d;
  logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
  logic [LEN_BW-1:0]  len_cnt_q, len_cnt_d;
  logic [LEN_BW-1:0]  len_last_q, len_last_d;
  logic [MOD_BW-1:0]  mod_q, mod_d;
  logic [AMP_BW-1:0]  amp_q, amp_d;
  logic [SPS_BW-1:0]  sps_q, sps_d;
  logic               start_q, start_d;

  entry_t wr_data, rd_data;
  logic   accept, last_acc, more, loop_en;

  assign wr_data.mod = bus.tbl_wr_mod;
  assign wr_data.amp = bus.tbl_wr_amp;
  assign wr_data.sps = bus.tbl_wr_sps;
  assign wr_data.len = bus.tbl_wr_len;

  // Read address follows the next entry so the data is ready during the single LOAD cycle.
  burst_sched_table #(.DEPTH(DEPTH)) u_table (
    .ap_clk    (ap_clk),
    .wr_en_i   (bus.tbl_wr_en),
    .wr_addr_i (bus.tbl_wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (entry_d),
    .rd_data_o (rd_data)
  );

`ifdef BURST_SCHED_LOOP_EN
  assign loop_en = bus.ctrl_loop;
`else
  logic unused_loop;
  assign loop_en     = 1'b0;
  assign unused_loop = bus.ctrl_loop;
`endif

  assign accept   = bus.iq_tvalid & bus.iq_tready;
  assign last_acc = (state_q == RUN) && accept && (len_cnt_q == len_last_q);
  assign more     = ({1'b0, entry_q} + NENT_ONE) < nent_q;

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    nent_d     = nent_q;
    set_cnt_d  = set_cnt_q;
    len_cnt_d  = len_cnt_q;
    len_last_d = len_last_q;
    mod_d      = mod_q;
    amp_d      = amp_q;
    sps_d      = sps_q;
    start_d    = start_q;
    case (state_q)
      IDLE: begin
        if (bus.ctrl_go && (bus.num_entries != '0)) begin
          state_d = LOAD;
          entry_d = '0;
          nent_d  = bus.num_entries;
        end
      end
      LOAD: begin
        mod_d      = rd_data.mod;
        amp_d      = rd_data.amp;
        sps_d      = rd_data.sps;
        // A zero-length burst plays one sample.
        len_last_d = (rd_data.len == '0) ? '0 : rd_data.len - LEN_ONE;
        start_d    = 1'b1;
        set_cnt_d  = '0;
        len_cnt_d  = '0;
        state_d    = (SETTLE_SAMP == 0) ? RUN : SETTLE;
      end
      SETTLE: begin
        if (accept) begin
          if (set_cnt_q == SET_LAST) begin
            set_cnt_d = '0;
            state_d   = RUN;
          end else begin
            set_cnt_d = set_cnt_q + SET_ONE;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (len_cnt_q == len_last_q) begin
            len_cnt_d = '0;
            if (more) begin
              entry_d = entry_q + ENT_ONE;
              state_d = LOAD;
            end else if (loop_en) begin
              entry_d = '0;
              state_d = LOAD;
            end else begin
              state_d = IDLE;
              start_d = 1'b0;
            end
          end else begin
            len_cnt_d = len_cnt_q + LEN_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Stop overrides everything, including a go in the same cycle.
    if (bus.ctrl_stop) begin
      state_d   = IDLE;
      start_d   = 1'b0;
      entry_d   = '0;
      set_cnt_d = '0;
      len_cnt_d = '0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= IDLE;
      entry_q    <= '0;
      nent_q     <= '0;
      set_cnt_q  <= '0;
      len_cnt_q  <= '0;
      len_last_q <= '0;
      mod_q      <= MOD_RST;
      amp_q      <= AMP_RST;
      sps_q      <= SPS_RST;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      nent_q     <= nent_d;
      set_cnt_q  <= set_cnt_d;
      len_cnt_q  <= len_cnt_d;
      len_last_q <= len_last_d;
      mod_q      <= mod_d;
      amp_q      <= amp_d;
      sps_q      <= sps_d;
      start_q    <= start_d;
    end
  end

  assign bus.mod_type           = mod_q;
  assign bus.amplitude          = amp_q;
  assign bus.samples_per_symbol = sps_q;
  assign bus.start              = start_q;
  assign bus.iq_gate            = (state_q == RUN);
  assign bus.busy               = (state_q != IDLE);
  assign bus.cur_entry          = entry_q;
  assign bus.burst_done         = last_acc;

endmodule

// File: tb/tb_burst_scheduler.sv
// Directed bench for burst_scheduler with SETTLE_SAMP=4; loop test depends on BURST_SCHED_LOOP_EN.
module tb_burst_scheduler;
  import burst_sched_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst;
  int   checks = 0;
  int   errors = 0;

  logic [2:0]  exp_mod [16];
  logic [31:0] exp_amp [16];
  logic [31:0] exp_sps [16];
  int          exp_len [16];
  int gated_n [16];
  int valid_n [16];
  int done_n  [16];
  int cfg_bad, done_bad, done_noacc, max_entry;

  burst_scheduler_if #(.DEPTH(16)) b ();

  burst_scheduler #(.DEPTH(16), .SETTLE_SAMP(4)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (b)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wr_entry(input int a, input int m, input int amp, input int sps, input int len);
    tick();
    b.tbl_wr_en = 1'b1; b.tbl_wr_addr = 4'(a); b.tbl_wr_mod = 3'(m);
    b.tbl_wr_amp = 32'(amp); b.tbl_wr_sps = 32'(sps); b.tbl_wr_len = 24'(len);
    exp_mod[a] = 3'(m); exp_amp[a] = 32'(amp); exp_sps[a] = 32'(sps);
    exp_len[a] = (len == 0) ? 1 : len;
    tick();
    b.tbl_wr_en = 1'b0;
  endtask

  // Issues go, then runs until busy drops (bounded), collecting per-entry sample statistics.
  task automatic play(input bit bp, input bit wr0, input int nent, input int loop_bursts, output bit ok);
    bit wrote, clr_loop, acc;
    int idx, tot_done;
    wrote = 0; clr_loop = 0; ok = 0; tot_done = 0;
    for (int i = 0; i < 16; i++) begin gated_n[i] = 0; valid_n[i] = 0; done_n[i] = 0; end
    cfg_bad = 0; done_bad = 0; done_noacc = 0; max_entry = 0;
    tick();
    b.ctrl_go = 1'b1; b.num_entries = 5'(nent); b.iq_tvalid = 1'b1; b.iq_tready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tick();
      b.ctrl_go = 1'b0; b.tbl_wr_en = 1'b0;
      b.iq_tready = bp ? c[0] : 1'b1;
      if (clr_loop) b.ctrl_loop = 1'b0;
      if (wr0 && !wrote && b.cur_entry == 4'd1 && b.iq_gate) begin
        wrote = 1;
        b.tbl_wr_en = 1'b1; b.tbl_wr_addr = 4'd0; b.tbl_wr_mod = 3'd6;
        b.tbl_wr_amp = 32'd77; b.tbl_wr_sps = 32'd2; b.tbl_wr_len = 24'd2;
      end
      #1;
      acc = b.iq_tvalid & b.iq_tready;
      idx = int'(b.cur_entry);
      if (idx > max_entry) max_entry = idx;
      if (acc && b.start && !b.iq_gate && b.mod_type == exp_mod[idx]) gated_n[idx]++;
      if (acc && b.iq_gate) begin
        valid_n[idx]++;
        if (b.mod_type !== exp_mod[idx] || b.amplitude !== exp_amp[idx] ||
            b.samples_per_symbol !== exp_sps[idx]) cfg_bad++;
      end
      if (b.burst_done) begin
        done_n[idx]++; tot_done++;
        if (!acc) done_noacc++;
        if (valid_n[idx] != exp_len[idx] * done_n[idx]) done_bad++;
        if (loop_bursts > 0 && tot_done == loop_bursts) clr_loop = 1;
      end
      if (!b.busy) begin ok = 1; break; end
    end
    b.tbl_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    b.tbl_wr_en = 0; b.tbl_wr_addr = 0; b.tbl_wr_mod = 0; b.tbl_wr_amp = 0; b.tbl_wr_sps = 0;
    b.tbl_wr_len = 0; b.num_entries = 0; b.ctrl_go = 0; b.ctrl_stop = 0; b.ctrl_loop = 0;
    b.iq_tvalid = 0; b.iq_tready = 0;
    tick(); tick();
    ap_rst = 1'b0;
    tick(); #1;
    checks++; if (b.mod_type !== 3'd0) begin errors++; $display("FAIL reset_mod: got %0d exp 0", b.mod_type); end
    checks++; if (b.amplitude !== 32'd1024) begin errors++; $display("FAIL reset_amp: got %0d exp 1024", b.amplitude); end
    checks++; if (b.samples_per_symbol !== 32'd4) begin errors++; $display("FAIL reset_sps: got %0d exp 4", b.samples_per_symbol); end
    checks++; if (b.start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b exp 0", b.start); end
    checks++; if (b.iq_gate !== 1'b0) begin errors++; $display("FAIL reset_gate: got %0b exp 0", b.iq_gate); end
    checks++; if (b.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", b.busy); end
    checks++; if (b.cur_entry !== 4'd0) begin errors++; $display("FAIL reset_entry: got %0d exp 0", b.cur_entry); end
    checks++; if (b.burst_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b exp 0", b.burst_done); end
  endtask

  task automatic test_two_bursts(input bit bp, input string nm);
    bit ok;
    wr_entry(0, 1, 2000, 8, 10);
    wr_entry(1, 3, 500, 4, 5);
    play(bp, 0, 2, 0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL %s_timeout: busy never dropped", nm); end
    checks++; if (gated_n[0] != 4) begin errors++; $display("FAIL %s_gated0: got %0d exp 4", nm, gated_n[0]); end
    checks++; if (valid_n[0] != 10) begin errors++; $display("FAIL %s_valid0: got %0d exp 10", nm, valid_n[0]); end
    checks++; if (done_n[0] != 1) begin errors++; $display("FAIL %s_done0: got %0d exp 1", nm, done_n[0]); end
    checks++; if (gated_n[1] != 4) begin errors++; $display("FAIL %s_gated1: got %0d exp 4", nm, gated_n[1]); end
    checks++; if (valid_n[1] != 5) begin errors++; $display("FAIL %s_valid1: got %0d exp 5", nm, valid_n[1]); end
    checks++; if (done_n[1] != 1) begin errors++; $display("FAIL %s_done1: got %0d exp 1", nm, done_n[1]); end
    checks++; if (cfg_bad != 0) begin errors++; $display("FAIL %s_cfg: %0d valid samples with wrong config, exp 0", nm, cfg_bad); end
    checks++; if (done_bad != 0 || done_noacc != 0) begin errors++; $display("FAIL %s_done_timing: bad=%0d noacc=%0d exp 0/0", nm, done_bad, done_noacc); end
    checks++; if (b.start !== 1'b0 || b.iq_gate !== 1'b0) begin errors++; $display("FAIL %s_idle_out: start=%0b gate=%0b exp 0/0", nm, b.start, b.iq_gate); end
    checks++; if (b.mod_type !== 3'd3 || b.amplitude !== 32'd500) begin errors++; $display("FAIL %s_hold: mod=%0d amp=%0d exp 3/500", nm, b.mod_type, b.amplitude); end
  endtask

  task automatic test_stop();
    bit ok, seen;
    seen = 0;
    tick(); b.ctrl_go = 1'b1; b.num_entries = 5'd2; b.iq_tvalid = 1'b1; b.iq_tready = 1'b1;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick(); b.ctrl_go = 1'b0; #1;
      if (b.iq_gate) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL stop_reach_run: iq_gate never rose"); end
    tick(); tick(); tick();
    b.ctrl_stop = 1'b1;
    tick(); b.ctrl_stop = 1'b0; #1;
    checks++; if (b.busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %0b exp 0", b.busy); end
    checks++; if (b.start !== 1'b0) begin errors++; $display("FAIL stop_start: got %0b exp 0", b.start); end
    checks++; if (b.iq_gate !== 1'b0) begin errors++; $display("FAIL stop_gate: got %0b exp 0", b.iq_gate); end
    play(0, 0, 2, 0, ok);
    checks++; if (ok !== 1'b1 || gated_n[0] != 4 || valid_n[0] != 10) begin errors++; $display("FAIL stop_restart: ok=%0b gated0=%0d valid0=%0d exp 1/4/10", ok, gated_n[0], valid_n[0]); end
    checks++; if (valid_n[1] != 5 || done_n[1] != 1) begin errors++; $display("FAIL stop_restart1: valid1=%0d done1=%0d exp 5/1", valid_n[1], done_n[1]); end
  endtask

  task automatic test_go_ignored();
    tick(); b.ctrl_go = 1'b1; b.ctrl_stop = 1'b1; b.num_entries = 5'd2;
    tick(); b.ctrl_go = 1'b0; b.ctrl_stop = 1'b0; #1;
    checks++; if (b.busy !== 1'b0) begin errors++; $display("FAIL go_stop_busy: got %0b exp 0", b.busy); end
    tick(); b.ctrl_go = 1'b1; b.num_entries = 5'd0;
    tick(); b.ctrl_go = 1'b0; #1;
    checks++; if (b.busy !== 1'b0) begin errors++; $display("FAIL go_zero_busy: got %0b exp 0", b.busy); end
    tick(); #1;
    checks++; if (b.busy !== 1'b0 || b.start !== 1'b0) begin errors++; $display("FAIL go_zero_late: busy=%0b start=%0b exp 0/0", b.busy, b.start); end
    checks++; if (b.mod_type !== 3'd3) begin errors++; $display("FAIL go_zero_hold: mod=%0d exp 3", b.mod_type); end
  endtask

  task automatic test_len_zero();
    bit ok;
    wr_entry(0, 2, 100, 2, 0);
    play(0, 0, 1, 0, ok);
    checks++; if (ok !== 1'b1 || valid_n[0] != 1 || done_n[0] != 1) begin errors++; $display("FAIL len0: ok=%0b valid=%0d done=%0d exp 1/1/1", ok, valid_n[0], done_n[0]); end
    checks++; if (gated_n[0] != 4) begin errors++; $display("FAIL len0_gated: got %0d exp 4", gated_n[0]); end
  endtask

  task automatic test_loop();
    bit ok;
    wr_entry(0, 4, 300, 2, 3);
    b.ctrl_loop = 1'b1;
`ifdef BURST_SCHED_LOOP_EN
    play(0, 0, 1, 4, ok);
    checks++; if (ok !== 1'b1 || done_n[0] != 5 || valid_n[0] != 15) begin errors++; $display("FAIL loop: ok=%0b done=%0d valid=%0d exp 1/5/15", ok, done_n[0], valid_n[0]); end
    checks++; if (max_entry != 0 || done_bad != 0 || cfg_bad != 0) begin errors++; $display("FAIL loop_entry: max_entry=%0d bad=%0d cfg=%0d exp 0/0/0", max_entry, done_bad, cfg_bad); end
`else
    play(0, 0, 1, 0, ok);
    checks++; if (ok !== 1'b1 || done_n[0] != 1 || valid_n[0] != 3) begin errors++; $display("FAIL noloop: ok=%0b done=%0d valid=%0d exp 1/1/3", ok, done_n[0], valid_n[0]); end
`endif
    b.ctrl_loop = 1'b0;
  endtask

  task automatic test_async_reset_rewrite();
    bit ok;
    wr_entry(0, 1, 2000, 8, 10);
    wr_entry(1, 3, 500, 4, 5);
    tick(); b.ctrl_go = 1'b1; b.num_entries = 5'd2; b.iq_tvalid = 1'b1; b.iq_tready = 1'b1;
    tick(); b.ctrl_go = 1'b0;
    tick(); #1;
    checks++; if (b.start !== 1'b1 || b.iq_gate !== 1'b0 || b.mod_type !== 3'd1) begin errors++; $display("FAIL arst_pre: start=%0b gate=%0b mod=%0d exp 1/0/1", b.start, b.iq_gate, b.mod_type); end
    ap_rst = 1'b1; #1;
    checks++; if (b.mod_type !== 3'd0 || b.amplitude !== 32'd1024 || b.samples_per_symbol !== 32'd4) begin errors++; $display("FAIL arst_cfg: mod=%0d amp=%0d sps=%0d exp 0/1024/4", b.mod_type, b.amplitude, b.samples_per_symbol); end
    checks++; if (b.start !== 1'b0 || b.busy !== 1'b0 || b.iq_gate !== 1'b0 || b.cur_entry !== 4'd0 || b.burst_done !== 1'b0) begin errors++; $display("FAIL arst_ctl: start=%0b busy=%0b gate=%0b entry=%0d done=%0b exp all 0", b.start, b.busy, b.iq_gate, b.cur_entry, b.burst_done); end
    tick(); ap_rst = 1'b0;
    play(0, 1, 2, 0, ok);
    checks++; if (ok !== 1'b1 || valid_n[0] != 10 || valid_n[1] != 5 || cfg_bad != 0) begin errors++; $display("FAIL arst_table: ok=%0b valid0=%0d valid1=%0d cfg=%0d exp 1/10/5/0", ok, valid_n[0], valid_n[1], cfg_bad); end
    exp_mod[0] = 3'd6; exp_amp[0] = 32'd77; exp_sps[0] = 32'd2; exp_len[0] = 2;
    play(0, 0, 2, 0, ok);
    checks++; if (ok !== 1'b1 || valid_n[0] != 2 || gated_n[0] != 4 || done_n[0] != 1) begin errors++; $display("FAIL rewrite: ok=%0b valid0=%0d gated0=%0d done0=%0d exp 1/2/4/1", ok, valid_n[0], gated_n[0], done_n[0]); end
    checks++; if (cfg_bad != 0 || done_bad != 0) begin errors++; $display("FAIL rewrite_cfg: cfg=%0d bad=%0d exp 0/0", cfg_bad, done_bad); end
  endtask

  initial begin
    test_reset();
    test_two_bursts(1'b0, "basic");
    test_two_bursts(1'b1, "backpressure");
    test_stop();
    test_go_ignored();
    test_len_zero();
    test_loop();
    test_async_reset_rewrite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
